// File: rtl/alu_seq.sv
// ============================================================================
// Module   : alu_seq
// Purpose  : Multi-cycle sequencer computing 32-bit unsigned MUL (low word),
//            DIVU and REMU by driving an external add/sub/or/and ALU once per
//            cycle (shift-add multiply, restoring divide).
// Revision : 1.0 - initial release
//
// Build option:
//   ALU_SEQ_ZERO_SKIP_EN - when defined, MUL finishes as soon as no multiplier
//                          bits remain, and a zero divisor or zero multiplier
//                          goes straight to DONE. Results are identical.
//
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   synchronous active-low reset
//   req_valid_i   in   request valid
//   req_ready_o   out  request accepted when valid & ready (IDLE only)
//   req_op_i      in   00 MUL, 01 MUL (reserved), 10 DIVU, 11 REMU
//   req_a_i       in   multiplicand / dividend
//   req_b_i       in   multiplier / divisor
//   resp_valid_o  out  result valid (DONE)
//   resp_ready_i  in   consumer accepts result when valid & ready
//   resp_data_o   out  result, zero outside DONE
//   busy_o        out  high in CALC and DONE
//   alu_srca_o    out  ALU operand A
//   alu_srcb_o    out  ALU operand B
//   alu_ctrl_o    out  ALU op (00 add, 01 sub)
//   alu_result_i  in   ALU result, combinational on alu_* outputs
// ============================================================================
`default_nettype none

module alu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        busy_o,
  output logic [31:0] alu_srca_o,
  output logic [31:0] alu_srcb_o,
  output logic [1:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  op;
  logic [31:0] acc;   // MUL accumulator, or partial remainder for DIV/REM
  logic [31:0] m;     // shifted multiplicand
  logic [31:0] q;     // multiplier (MUL) or dividend/quotient shift register
  logic [31:0] d;     // divisor
  logic [4:0]  cnt;

  logic        is_div;
  logic [31:0] div_s;
  logic        div_c;
  logic        div_ok;
  logic [31:0] q_shr;
  logic        last;

  assign is_div = op[1];

  // Next partial remainder candidate: shift in the next dividend bit.
  assign div_s = {acc[30:0], q[31]};

  // Carry-out of s + ~d + 1, rebuilt from the MSBs since the ALU exposes only
  // the 32-bit sum: set when s >= d.
  assign div_c  = (div_s[31] & ~d[31]) | ((div_s[31] | ~d[31]) & ~alu_result_i[31]);
  // A set acc[31] means the true 33-bit partial remainder exceeds any divisor.
  assign div_ok = acc[31] | div_c;

  assign q_shr = {1'b0, q[31:1]};

`ifdef ALU_SEQ_ZERO_SKIP_EN
  assign last = (cnt == 5'd31) || (!is_div && (q_shr == 32'd0));
`else
  assign last = (cnt == 5'd31);
`endif

  // ALU drive: idle/done states present zeros and an add.
  always_comb begin
    alu_srca_o = 32'd0;
    alu_srcb_o = 32'd0;
    alu_ctrl_o = 2'b00;
    if (state == S_CALC) begin
      if (is_div) begin
        alu_srca_o = div_s;
        alu_srcb_o = d;
        alu_ctrl_o = 2'b01;
      end else begin
        alu_srca_o = acc;
        alu_srcb_o = q[0] ? m : 32'd0;
        alu_ctrl_o = 2'b00;
      end
    end
  end

  // DIVU returns the quotient register; MUL and REMU share acc.
  always_comb begin
    resp_data_o = 32'd0;
    if (state == S_DONE)
      resp_data_o = (op == 2'b10) ? q : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op           <= 2'b00;
      acc          <= 32'd0;
      m            <= 32'd0;
      q            <= 32'd0;
      d            <= 32'd0;
      cnt          <= 5'd0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            op          <= req_op_i;
            cnt         <= 5'd0;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= S_CALC;
            if (req_op_i[1]) begin
              acc <= 32'd0;
              m   <= 32'd0;
              q   <= req_a_i;
              d   <= req_b_i;
`ifdef ALU_SEQ_ZERO_SKIP_EN
              if (req_b_i == 32'd0) begin
                acc          <= req_a_i;
                q            <= 32'hFFFF_FFFF;
                state        <= S_DONE;
                resp_valid_o <= 1'b1;
              end
`endif
            end else begin
              acc <= 32'd0;
              m   <= req_a_i;
              q   <= req_b_i;
              d   <= 32'd0;
`ifdef ALU_SEQ_ZERO_SKIP_EN
              if (req_b_i == 32'd0) begin
                state        <= S_DONE;
                resp_valid_o <= 1'b1;
              end
`endif
            end
          end
        end

        S_CALC: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc <= div_ok ? alu_result_i : div_s;
            q   <= {q[30:0], div_ok};
          end else begin
            acc <= alu_result_i;
            m   <= {m[30:0], 1'b0};
            q   <= q_shr;
          end
          if (last) begin
            state        <= S_DONE;
            resp_valid_o <= 1'b1;
          end
        end

        S_DONE: begin
          if (resp_ready_i) begin
            state        <= S_IDLE;
            resp_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end

        default: begin
          state        <= S_IDLE;
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq. Models the external ALU,
//            drives directed and random operations, and compares results and
//            response latency against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [1:0]  alu_ctrl;
  logic [31:0] alu_result;

  int n_checks = 0;
  int n_err    = 0;

  alu_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .busy_o       (busy),
    .alu_srca_o   (alu_srca),
    .alu_srcb_o   (alu_srcb),
    .alu_ctrl_o   (alu_ctrl),
    .alu_result_i (alu_result)
  );

  // The shared ALU: add / sub / or / and.
  assign alu_result = (alu_ctrl == 2'b00) ? alu_srca + alu_srcb :
                      (alu_ctrl == 2'b01) ? alu_srca - alu_srcb :
                      (alu_ctrl == 2'b10) ? (alu_srca | alu_srcb) :
                                            (alu_srca & alu_srcb);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b11:   return (b == 0) ? a : a % b;
      default: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
    endcase
  endfunction

  // Cycles from the request handshake edge until resp_valid is first seen.
  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_ZERO_SKIP_EN
    int msb;
    if (b == 0) return 1;
    if (!op[1]) begin
      msb = 0;
      for (int i = 0; i < 32; i++) if (b[i]) msb = i;
      return msb + 2;
    end
`endif
    return 33;
  endfunction

  // Present a request at a negedge and return at the negedge after the handshake.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_accept_timeout", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called on the first negedge after the handshake (cycle T+1).
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    int exp_lat;
    exp_lat = ref_latency(op, b);
    resp_ready = 1'b1;
    issue(op, a, b);
    if (exp_lat > 1) begin
      check({tag, "_calc_busy"}, {30'd0, busy, req_ready}, 32'd2);
      check({tag, "_calc_ctrl"}, {30'd0, alu_ctrl}, op[1] ? 32'd1 : 32'd0);
    end
    wait_resp(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, resp_data, ref_result(op, a, b));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_after"}, {28'd0, resp_valid, req_ready, busy, |alu_srca}, 32'd4);
  endtask

  initial begin
    int lat;
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu", alu_srca | alu_srcb | {30'd0, alu_ctrl}, 32'd0);
    rst_n = 1'b1;

    // Directed operations
    run_op("mul_7x6", 2'b00, 32'd7, 32'd6);
    run_op("mul_ffx2", 2'b00, 32'hFFFF_FFFF, 32'd2);
    run_op("mul_x0", 2'b00, 32'h1234_5678, 32'd0);
    run_op("mul_rsvd", 2'b01, 32'd11, 32'd13);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
    run_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0);

    // Backpressure in DONE with a pending request
    resp_ready = 1'b0;
    issue(2'b10, 32'd100, 32'd7);
    wait_resp(lat);
    check("bp_latency", lat, 32'd33);
    check("bp_data", resp_data, 32'd14);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_a     = 32'd100;
    req_b     = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {resp_data[29:0], resp_valid, req_ready}, {30'd14, 1'b1, 1'b0});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_released", {30'd0, resp_valid, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_pending_taken", {31'd0, busy}, 32'd1);
    wait_resp(lat);
    check("bp_pending_latency", lat, 32'd33);
    check("bp_pending_data", resp_data, 32'd2);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of CALC aborts the operation
    issue(2'b00, 32'h1234_5678, 32'h0000_FFFF);
    repeat (9) @(negedge clk);
    check("abort_in_calc", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_outputs", {28'd0, req_ready, resp_valid, busy, |resp_data}, 32'd8);
    check("abort_alu", alu_srca | alu_srcb | {30'd0, alu_ctrl}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("abort_no_resp", seen, 32'd0);
    run_op("mul_3x3", 2'b00, 32'd3, 32'd3);

    // Random operations against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 255);
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that performs 32-bit unsigned multiply, divide and remainder by driving the existing 2-bit-op ALU (add/sub/or/and) over many cycles. It sits beside the execute stage, owns a dedicated ALU instance, and accepts one operation at a time through a valid/ready request channel. It returns the result through a valid/ready response channel.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_op_i  in  2  00 MUL (low 32 bits of product), 01 reserved (treated as MUL), 10 DIVU, 11 REMU
- req_a_i  in  32  multiplicand / dividend
- req_b_i  in  32  multiplier / divisor
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer takes result when valid&ready
- resp_data_o  out  32  result
- busy_o  out  1  high in CALC and DONE
- alu_srca_o  out  32  to ALU operand A
- alu_srcb_o  out  32  to ALU operand B
- alu_ctrl_o  out  2  to ALU op: 00 add, 01 sub (a + ~b + 1)
- alu_result_i  in  32  from ALU, combinational on alu_* outputs

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: req_ready_o=1. On req_valid_i, latch op, a, b and clear cnt; go to CALC.
- Registers: acc/r (32), m (32), q (32), d (32), cnt (5).
- MUL capture: acc=0, m=a, q=b.
- MUL per CALC cycle: alu_srca_o=acc, alu_srcb_o = q[0] ? m : 0, alu_ctrl_o=00. Then acc<=alu_result_i, m<=m<<1, q<=q>>1.
- DIV/REM capture: r=0, q=a, d=b.
- DIV/REM per CALC cycle (restoring): s = {r[30:0], q[31]}. Drive alu_srca_o=s, alu_srcb_o=d, alu_ctrl_o=01.
  - Carry from MSBs: c = (s[31]&~d[31]) | ((s[31]|~d[31]) & ~alu_result_i[31]).
  - ok = r[31] | c. Then r <= ok ? alu_result_i : s, q <= {q[30:0], ok}.
- CALC: cnt increments each cycle. After the cycle with cnt==31, go to DONE.
- DONE: resp_valid_o=1. resp_data_o = acc for MUL, q for DIVU, r for REMU. Data stays stable until resp_ready_i; on handshake, go to IDLE.
- req_ready_o=0 in CALC and DONE. A request presented then is held by the requester and not lost.
- Divide by zero follows RISC-V without special-casing: DIVU yields 0xFFFFFFFF, REMU yields the dividend.
- In IDLE and DONE, alu_srca_o=alu_srcb_o=0 and alu_ctrl_o=00.
- Overflow beyond 32 bits in MUL is discarded.

## Timing
- Reset (rst_n low at an edge): state=IDLE; all registers 0; req_ready_o=1, resp_valid_o=0, resp_data_o=0, busy_o=0, alu_* outputs 0.
- Reset mid-CALC or mid-DONE aborts the operation; no response is produced.
- Request handshake at edge T. CALC occupies cycles T+1..T+32. resp_valid_o is high from cycle T+33.
- Result handshake in cycle N returns to IDLE at N+1. The earliest next request handshake is at the end of cycle N+1 (no same-cycle turnaround).
- resp_valid_o never deasserts without resp_ready_i.

## Configuration
- ALU_SEQ_ZERO_SKIP_EN defined, MUL: CALC exits as soon as q (after update) is zero.
  - MUL with b==0 goes IDLE->DONE directly, so resp_valid_o is high at T+1.
  - Otherwise the number of CALC cycles is msb_index(b)+1.
- ALU_SEQ_ZERO_SKIP_EN defined, DIVU/REMU with b==0: goes IDLE->DONE directly with q=0xFFFFFFFF and r=a.
- ALU_SEQ_ZERO_SKIP_EN defined, DIVU/REMU with b!=0: unchanged, 32 cycles.
- ALU_SEQ_ZERO_SKIP_EN undefined: every operation takes exactly 32 CALC cycles. Results are identical in both builds.

## Test plan
- MUL a=7, b=6, resp_ready_i=1: response 42 at T+33 (undefined build) or at T+4 (defined build).
- MUL a=0xFFFFFFFF, b=2: response 0xFFFFFFFE. MUL a=0x12345678, b=0: response 0 (T+1 when skip is enabled).
- DIVU 100/7 gives 14; REMU 100/7 gives 2. DIVU 0xFFFFFFFF/0x80000001 gives 1; REMU of the same gives 0x7FFFFFFE (exercises the r[31]/carry path).
- DIVU 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5.
- Backpressure: hold resp_ready_i=0 for 5 cycles in DONE.
  - resp_data_o stays stable and req_ready_o stays 0 throughout.
  - A pending req_valid_i is accepted only after the response handshake.
- Reset: rst_n=0 for one cycle at CALC cycle 10. Next cycle is IDLE with all outputs 0 and no response. A fresh MUL 3*3 then returns 9.
